// File: rtl/arp_ctrl.sv
// ARP sequencing controller: single-entry IP->MAC cache, request/retry FSM,
// reply scheduling and one-trigger-per-frame arbitration toward the ARP TX framer.
module arp_ctrl #(
    parameter logic [31:0] P_TIMEOUT   = 32'd125000,
    parameter logic [3:0]  P_MAX_RETRY = 4'd3,
    parameter logic [15:0] P_ARP_LEN   = 16'd46
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lookup_ip,
    input  logic        i_lookup_valid,
    output logic        o_lookup_ready,
    output logic [47:0] o_lookup_mac,
    output logic        o_lookup_done,
    output logic        o_lookup_fail,
    input  logic        i_rx_reply_valid,
    input  logic [31:0] i_rx_reply_ip,
    input  logic [47:0] i_rx_reply_mac,
    input  logic        i_rx_req_valid,
    input  logic [31:0] i_rx_req_ip,
    input  logic [47:0] i_rx_req_mac,
    output logic [31:0] o_dst_ip,
    output logic        o_dst_ip_valid,
    output logic [47:0] o_reply_mac,
    output logic        o_trig_reply,
    output logic        o_active_req,
    input  logic        i_tx_last,
    output logic        o_cache_valid,
    output logic [31:0] o_cache_ip,
    output logic [47:0] o_cache_mac
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REQ, S_WAIT_TX, S_WAIT_RSP, S_DONE, S_FAIL
    } state_t;

    localparam logic [17:0] WD_LAST   = {P_ARP_LEN, 2'b00} - 18'd1;
    localparam logic [31:0] TMO_START = (P_TIMEOUT == 32'd0) ? 32'd0 : P_TIMEOUT - 32'd1;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lk_ip;
    logic [3:0]  retry_cnt;
    logic [31:0] tmo_cnt;
    logic        rep_pend;
    logic [31:0] rep_ip;
    logic [47:0] rep_mac;
    logic        busy;
    logic [17:0] wd_cnt;

    logic grant;
    logic issue_reply;
    logic issue_req;
    logic reply_match;
    logic hit;

    // A freshly arriving peer request also defers our own request, so the reply goes first.
    assign grant       = !busy && !i_tx_last;
    assign issue_reply = grant && rep_pend;
    assign issue_req   = grant && !rep_pend && !i_rx_req_valid && (state == S_REQ);
    assign reply_match = i_rx_reply_valid && (i_rx_reply_ip == lk_ip);
    assign hit         = o_cache_valid && (o_cache_ip == lk_ip);

    assign o_lookup_ready = (state == S_IDLE);
    assign o_lookup_done  = (state == S_DONE);
    assign o_lookup_fail  = (state == S_FAIL);
    assign o_lookup_mac   = (state == S_DONE) ? o_cache_mac : 48'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (i_lookup_valid) state_nxt = S_CHECK;
            S_CHECK:    state_nxt = hit ? S_DONE : S_REQ;
            S_REQ:      if (issue_req) state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (reply_match)    state_nxt = S_DONE;
                else if (i_tx_last) state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (reply_match)
                    state_nxt = S_DONE;
                else if (tmo_cnt == 32'd0)
                    state_nxt = (retry_cnt < P_MAX_RETRY) ? S_REQ : S_FAIL;
            end
            S_DONE:     state_nxt = S_IDLE;
            S_FAIL:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            lk_ip          <= 32'd0;
            retry_cnt      <= 4'd0;
            tmo_cnt        <= 32'd0;
            rep_pend       <= 1'b0;
            rep_ip         <= 32'd0;
            rep_mac        <= 48'd0;
            busy           <= 1'b0;
            wd_cnt         <= 18'd0;
            o_cache_valid  <= 1'b0;
            o_cache_ip     <= 32'd0;
            o_cache_mac    <= 48'd0;
            o_dst_ip       <= 32'd0;
            o_dst_ip_valid <= 1'b0;
            o_reply_mac    <= 48'd0;
            o_trig_reply   <= 1'b0;
            o_active_req   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && i_lookup_valid)
                lk_ip <= i_lookup_ip;

            if (state == S_CHECK)
                retry_cnt <= 4'd0;
            else if (issue_req)
                retry_cnt <= retry_cnt + 4'd1;

            // Timeout only runs in WAIT_RSP; time spent waiting for the grant is not counted.
            if (state == S_WAIT_TX && i_tx_last)
                tmo_cnt <= TMO_START;
            else if (state == S_WAIT_RSP && tmo_cnt != 32'd0)
                tmo_cnt <= tmo_cnt - 32'd1;

            if (reply_match && (state == S_WAIT_TX || state == S_WAIT_RSP)) begin
                o_cache_valid <= 1'b1;
                o_cache_ip    <= i_rx_reply_ip;
                o_cache_mac   <= i_rx_reply_mac;
            end

            if (i_rx_req_valid) begin
                rep_pend <= 1'b1;
                rep_ip   <= i_rx_req_ip;
                rep_mac  <= i_rx_req_mac;
            end else if (issue_reply) begin
                rep_pend <= 1'b0;
            end

            o_trig_reply   <= issue_reply;
            o_active_req   <= issue_req;
            o_dst_ip_valid <= issue_reply || issue_req;
            if (issue_reply) begin
                o_dst_ip    <= rep_ip;
                o_reply_mac <= rep_mac;
            end else if (issue_req) begin
                o_dst_ip <= lk_ip;
            end

            // Watchdog frees the framer slot if o_mac_last never arrives.
            if (issue_reply || issue_req) begin
                busy   <= 1'b1;
                wd_cnt <= 18'd0;
            end else if (busy) begin
                if (i_tx_last || wd_cnt == WD_LAST) begin
                    busy   <= 1'b0;
                    wd_cnt <= 18'd0;
                end else begin
                    wd_cnt <= wd_cnt + 18'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with a simple framer model answering each trigger
// with o_mac_last FL cycles later.
module tb_arp_ctrl;

    localparam int FL = 10;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_lookup_ip = 32'd0;
    logic        i_lookup_valid = 1'b0;
    logic        o_lookup_ready;
    logic [47:0] o_lookup_mac;
    logic        o_lookup_done;
    logic        o_lookup_fail;
    logic        i_rx_reply_valid = 1'b0;
    logic [31:0] i_rx_reply_ip = 32'd0;
    logic [47:0] i_rx_reply_mac = 48'd0;
    logic        i_rx_req_valid = 1'b0;
    logic [31:0] i_rx_req_ip = 32'd0;
    logic [47:0] i_rx_req_mac = 48'd0;
    logic [31:0] o_dst_ip;
    logic        o_dst_ip_valid;
    logic [47:0] o_reply_mac;
    logic        o_trig_reply;
    logic        o_active_req;
    logic        i_tx_last = 1'b0;
    logic        o_cache_valid;
    logic [31:0] o_cache_ip;
    logic [47:0] o_cache_mac;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int fr_cnt = 0;
    bit fr_en = 1'b1;
    int n_req = 0;
    int n_done = 0;
    int n_fail = 0;
    int req_cyc [4];

    arp_ctrl #(
        .P_TIMEOUT(32'd100),
        .P_MAX_RETRY(4'd3),
        .P_ARP_LEN(16'd46)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_lookup_ip(i_lookup_ip),
        .i_lookup_valid(i_lookup_valid),
        .o_lookup_ready(o_lookup_ready),
        .o_lookup_mac(o_lookup_mac),
        .o_lookup_done(o_lookup_done),
        .o_lookup_fail(o_lookup_fail),
        .i_rx_reply_valid(i_rx_reply_valid),
        .i_rx_reply_ip(i_rx_reply_ip),
        .i_rx_reply_mac(i_rx_reply_mac),
        .i_rx_req_valid(i_rx_req_valid),
        .i_rx_req_ip(i_rx_req_ip),
        .i_rx_req_mac(i_rx_req_mac),
        .o_dst_ip(o_dst_ip),
        .o_dst_ip_valid(o_dst_ip_valid),
        .o_reply_mac(o_reply_mac),
        .o_trig_reply(o_trig_reply),
        .o_active_req(o_active_req),
        .i_tx_last(i_tx_last),
        .o_cache_valid(o_cache_valid),
        .o_cache_ip(o_cache_ip),
        .o_cache_mac(o_cache_mac)
    );

    always #5 clk = ~clk;

    // One cycle: outputs sampled at the falling edge, pulse inputs cleared, framer model advanced.
    task automatic step();
        @(negedge clk);
        cyc++;
        i_lookup_valid   = 1'b0;
        i_rx_reply_valid = 1'b0;
        i_rx_req_valid   = 1'b0;
        i_tx_last        = 1'b0;
        if (fr_cnt != 0) begin
            fr_cnt--;
            if (fr_cnt == 0) i_tx_last = 1'b1;
        end
        if ((o_active_req || o_trig_reply) && fr_en) fr_cnt = FL;
        if (o_active_req) begin
            if (n_req < 4) req_cyc[n_req] = cyc;
            n_req++;
        end
        if (o_lookup_done) n_done++;
        if (o_lookup_fail) n_fail++;
    endtask

    task automatic clear_counts();
        n_req = 0; n_done = 0; n_fail = 0;
        for (int i = 0; i < 4; i++) req_cyc[i] = 0;
    endtask

    task automatic start_lookup(input logic [31:0] ip, output int t);
        step();
        i_lookup_ip    = ip;
        i_lookup_valid = 1'b1;
        t = cyc;
    endtask

    task automatic test_reset();
        repeat (3) step();
        i_rst = 1'b0;
        step();
        nvec++; if (o_lookup_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", o_lookup_ready); end
        nvec++; if (o_cache_valid !== 1'b0) begin nerr++; $display("FAIL reset_cache_valid: got %b want 0", o_cache_valid); end
        nvec++; if ({o_active_req, o_trig_reply, o_dst_ip_valid, o_lookup_done, o_lookup_fail} !== 5'b0)
            begin nerr++; $display("FAIL reset_pulses: got %b want 00000", {o_active_req, o_trig_reply, o_dst_ip_valid, o_lookup_done, o_lookup_fail}); end
        nvec++; if ({o_dst_ip, o_reply_mac, o_cache_ip, o_cache_mac, o_lookup_mac} !== 208'd0)
            begin nerr++; $display("FAIL reset_data: got %h want 0", {o_dst_ip, o_reply_mac, o_cache_ip, o_cache_mac, o_lookup_mac}); end
    endtask

    task automatic test_cold_lookup();
        int t;
        int r;
        bit seen;
        clear_counts();
        start_lookup(32'hC0A8_0A00, t);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (o_active_req) seen = 1'b1;
        end
        nvec++; if (!seen || cyc - t != 3) begin nerr++; $display("FAIL cold_req_latency: got %0d want 3 (seen=%0d)", cyc - t, seen); end
        nvec++; if (o_dst_ip !== 32'hC0A8_0A00 || o_dst_ip_valid !== 1'b1)
            begin nerr++; $display("FAIL cold_req_dst: got %h/%b want c0a80a00/1", o_dst_ip, o_dst_ip_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (i_tx_last) seen = 1'b1;
        end
        step();
        i_rx_reply_valid = 1'b1;
        i_rx_reply_ip    = 32'hC0A8_0A00;
        i_rx_reply_mac   = 48'h1122_3344_5566;
        r = cyc;
        step();
        nvec++; if (o_lookup_done !== 1'b1 || cyc != r + 1) begin nerr++; $display("FAIL cold_done: got %b want 1", o_lookup_done); end
        nvec++; if (o_lookup_mac !== 48'h1122_3344_5566) begin nerr++; $display("FAIL cold_mac: got %h want 112233445566", o_lookup_mac); end
        nvec++; if (o_cache_valid !== 1'b1 || o_cache_ip !== 32'hC0A8_0A00)
            begin nerr++; $display("FAIL cold_cache: got %b/%h want 1/c0a80a00", o_cache_valid, o_cache_ip); end
        step();
        nvec++; if (o_lookup_done !== 1'b0 || o_lookup_ready !== 1'b1)
            begin nerr++; $display("FAIL cold_after: got done=%b ready=%b want 0/1", o_lookup_done, o_lookup_ready); end
    endtask

    task automatic test_hit();
        int t;
        clear_counts();
        start_lookup(32'hC0A8_0A00, t);
        step();
        nvec++; if (o_lookup_done !== 1'b0 || o_lookup_ready !== 1'b0)
            begin nerr++; $display("FAIL hit_check_cycle: got done=%b ready=%b want 0/0", o_lookup_done, o_lookup_ready); end
        step();
        nvec++; if (o_lookup_done !== 1'b1 || o_lookup_mac !== 48'h1122_3344_5566)
            begin nerr++; $display("FAIL hit_done: got %b/%h want 1/112233445566", o_lookup_done, o_lookup_mac); end
        repeat (12) step();
        nvec++; if (n_req != 0 || n_done != 1) begin nerr++; $display("FAIL hit_no_frame: got req=%0d done=%0d want 0/1", n_req, n_done); end
    endtask

    task automatic test_retry_fail();
        int t;
        bit seen;
        clear_counts();
        start_lookup(32'hC0A8_0A01, t);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            step();
            if (o_lookup_fail) seen = 1'b1;
        end
        nvec++; if (!seen || cyc != t + 338) begin nerr++; $display("FAIL retry_fail_cycle: got %0d want %0d (seen=%0d)", cyc - t, 338, seen); end
        nvec++; if (n_req != 3) begin nerr++; $display("FAIL retry_count: got %0d want 3", n_req); end
        nvec++; if (req_cyc[0] != t + 3 || req_cyc[1] != t + 115 || req_cyc[2] != t + 227)
            begin nerr++; $display("FAIL retry_spacing: got %0d %0d %0d want 3 115 227", req_cyc[0] - t, req_cyc[1] - t, req_cyc[2] - t); end
        nvec++; if (o_cache_valid !== 1'b1 || o_cache_ip !== 32'hC0A8_0A00 || o_cache_mac !== 48'h1122_3344_5566)
            begin nerr++; $display("FAIL retry_cache: got %b/%h/%h want 1/c0a80a00/112233445566", o_cache_valid, o_cache_ip, o_cache_mac); end
        nvec++; if (n_done != 0) begin nerr++; $display("FAIL retry_no_done: got %0d want 0", n_done); end
    endtask

    task automatic test_reply_priority();
        int t;
        bit seen;
        clear_counts();
        start_lookup(32'hC0A8_0A02, t);
        step();
        step();
        i_rx_req_valid = 1'b1;
        i_rx_req_ip    = 32'hC0A8_0A05;
        i_rx_req_mac   = 48'hAABB_CCDD_EEFF;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (o_trig_reply || o_active_req) seen = 1'b1;
        end
        nvec++; if (!seen || o_trig_reply !== 1'b1 || o_active_req !== 1'b0 || cyc != t + 4)
            begin nerr++; $display("FAIL prio_first_trig: got rep=%b req=%b at %0d want 1/0 at 4", o_trig_reply, o_active_req, cyc - t); end
        nvec++; if (o_dst_ip !== 32'hC0A8_0A05 || o_reply_mac !== 48'hAABB_CCDD_EEFF || o_dst_ip_valid !== 1'b1)
            begin nerr++; $display("FAIL prio_reply_fields: got %h/%h/%b want c0a80a05/aabbccddeeff/1", o_dst_ip, o_reply_mac, o_dst_ip_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (o_active_req) seen = 1'b1;
        end
        nvec++; if (!seen || cyc != t + FL + 6) begin nerr++; $display("FAIL prio_req_after_last: got %0d want %0d", cyc - t, FL + 6); end
        nvec++; if (o_dst_ip !== 32'hC0A8_0A02 || o_reply_mac !== 48'hAABB_CCDD_EEFF)
            begin nerr++; $display("FAIL prio_req_fields: got %h/%h want c0a80a02/aabbccddeeff", o_dst_ip, o_reply_mac); end
        step();
        i_rx_reply_valid = 1'b1;
        i_rx_reply_ip    = 32'hC0A8_0A02;
        i_rx_reply_mac   = 48'h0A0B_0C0D_0E0F;
        step();
        nvec++; if (o_lookup_done !== 1'b1 || o_lookup_mac !== 48'h0A0B_0C0D_0E0F)
            begin nerr++; $display("FAIL prio_wait_tx_match: got %b/%h want 1/0a0b0c0d0e0f", o_lookup_done, o_lookup_mac); end
        repeat (12) step();
    endtask

    task automatic test_nonmatch();
        int t;
        clear_counts();
        start_lookup(32'hC0A8_0A03, t);
        while (cyc < t + 14) step();
        i_rx_reply_valid = 1'b1;
        i_rx_reply_ip    = 32'hC0A8_0A09;
        i_rx_reply_mac   = 48'h9999_9999_9999;
        step();
        nvec++; if (o_cache_ip !== 32'hC0A8_0A02 || o_cache_mac !== 48'h0A0B_0C0D_0E0F || o_lookup_done !== 1'b0)
            begin nerr++; $display("FAIL nonmatch_ignored: got %h/%h done=%b want c0a80a02/0a0b0c0d0e0f/0", o_cache_ip, o_cache_mac, o_lookup_done); end
        while (cyc < t + 113) step();
        i_rx_reply_valid = 1'b1;
        i_rx_reply_ip    = 32'hC0A8_0A03;
        i_rx_reply_mac   = 48'h0102_0304_0506;
        step();
        nvec++; if (o_lookup_done !== 1'b1 || o_lookup_mac !== 48'h0102_0304_0506)
            begin nerr++; $display("FAIL match_beats_timeout: got %b/%h want 1/010203040506", o_lookup_done, o_lookup_mac); end
        nvec++; if (o_cache_ip !== 32'hC0A8_0A03 || n_req != 1)
            begin nerr++; $display("FAIL match_cache_req: got %h req=%0d want c0a80a03/1", o_cache_ip, n_req); end
        repeat (4) step();
    endtask

    task automatic test_watchdog();
        int x;
        bit seen;
        fr_en = 1'b0;
        step();
        i_rx_req_valid = 1'b1;
        i_rx_req_ip    = 32'hC0A8_0A06;
        i_rx_req_mac   = 48'h0000_0000_0006;
        x = cyc;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (o_trig_reply) seen = 1'b1;
        end
        nvec++; if (!seen || cyc != x + 2) begin nerr++; $display("FAIL wd_first_reply: got %0d want 2", cyc - x); end
        step();
        i_rx_req_valid = 1'b1;
        i_rx_req_ip    = 32'hC0A8_0A07;
        i_rx_req_mac   = 48'h0000_0000_0007;
        fr_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (o_trig_reply) seen = 1'b1;
        end
        nvec++; if (!seen || cyc != x + 187 || o_dst_ip !== 32'hC0A8_0A07)
            begin nerr++; $display("FAIL wd_release: got %0d/%h want 187/c0a80a07", cyc - x, o_dst_ip); end
        repeat (FL + 2) step();
    endtask

    task automatic test_reset_mid();
        int t;
        bit seen;
        start_lookup(32'hC0A8_0A04, t);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (i_tx_last) seen = 1'b1;
        end
        repeat (5) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        nvec++; if (o_lookup_ready !== 1'b1 || o_lookup_done !== 1'b0 || o_lookup_fail !== 1'b0)
            begin nerr++; $display("FAIL rstmid_ctrl: got ready=%b done=%b fail=%b want 1/0/0", o_lookup_ready, o_lookup_done, o_lookup_fail); end
        nvec++; if (o_cache_valid !== 1'b0 || {o_cache_ip, o_cache_mac, o_dst_ip, o_reply_mac} !== 160'd0)
            begin nerr++; $display("FAIL rstmid_data: got v=%b %h want 0", o_cache_valid, {o_cache_ip, o_cache_mac, o_dst_ip, o_reply_mac}); end
        clear_counts();
        repeat (150) step();
        nvec++; if (n_done != 0 || n_fail != 0 || n_req != 0)
            begin nerr++; $display("FAIL rstmid_dropped: got done=%0d fail=%0d req=%0d want 0/0/0", n_done, n_fail, n_req); end
    endtask

    initial begin
        test_reset();
        test_cold_lookup();
        test_hit();
        test_retry_fail();
        test_reply_priority();
        test_nonmatch();
        test_watchdog();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
